m_mem_access: RTL and testbench
===============================

# m_mem_access

Memory-stage data access unit for the pipelined CPU, extending byte-lane steering and load extension into a multi-cycle, handshaked data-bus master. It sits in the M stage between the EX/MEM pipeline register and the data memory bus. It accepts one load or store per instruction, stalls the pipeline until the bus acknowledges, and returns extended load data. It also flags misaligned, out-of-range and timed-out accesses as exceptions.

## Interface
- DM_BASE, 32'h0000_0000, lowest legal data address (inclusive)
- DM_LIMIT, 32'h0000_2FFF, highest legal data address (inclusive)
- TIMEOUT, 16, max REQ cycles without ack before bus error (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- valid_M  in  1  M stage holds a real instruction
- INSTR_M  in  32  instruction in M (opcode = [31:26])
- ALUOUT_M  in  32  effective address
- WD_M  in  32  store data (rt value)
- stall_M  out  1  hold IF/ID/EX/M stages this cycle
- done_M  out  1  one-cycle pulse: access finished, DMOUT_M valid
- DMOUT_M  out  32  extended load data (registered)
- exc_M  out  1  one-cycle pulse: access aborted
- exc_code_M  out  5  4 = AdEL, 5 = AdES, 7 = bus timeout (DBE)
- m_data_req  out  1  bus request
- m_data_we  out  1  1 = store
- m_data_addr  out  32  byte address
- m_data_byteen  out  4  byte lanes (stores only, 0 for loads)
- m_data_wdata  out  32  lane-shifted store data
- m_data_ack  in  1  bus completion, sampled only while m_data_req = 1
- m_data_rdata  in  32  read word, valid with ack

## Operation
- Memops: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000. Any other opcode, or valid_M = 0, is not a memop and is ignored.
- Legal access: word needs addr[1:0] = 0, half needs addr[0] = 0, byte has no alignment rule. The address must also satisfy DM_BASE ≤ addr ≤ DM_LIMIT.
- Stores: byteen is 1111 for sw. For sh it is 0011 or 1100 by addr[1]. For sb it is 0001/0010/0100/1000 by addr[1:0]. wdata is WD_M shifted left by 8×(lowest enabled lane).
- Loads: the selected byte or half of rdata is sign-extended (lb, lh) or zero-extended (lbu, lhu); lw passes the word through. The result is latched into DMOUT_M on ack.
- FSM states: IDLE, REQ, DONE, EXC.
  - IDLE, legal memop: capture address, we, byteen, wdata, op and lane into output registers. Go to REQ.
  - IDLE, illegal memop: latch exc_code (AdEL for loads, AdES for stores). Go to EXC. No bus request is made.
  - REQ: m_data_req = 1 and the bus outputs are held stable. On ack, go to DONE and latch load data. If the timeout counter reaches TIMEOUT without ack, latch code 7 and go to EXC.
  - DONE: done_M = 1 for one cycle, then IDLE.
  - EXC: exc_M = 1 for one cycle, then IDLE.
- stall_M = (IDLE & memop) | REQ. This is combinational from state and the decoded inputs. stall_M is 0 in DONE and EXC, so the pipeline advances at the end of those cycles.
- Timeout counter: cleared on entry to REQ and incremented each REQ cycle without ack. Its width is $clog2(TIMEOUT+1).
- Outside REQ, m_data_req, m_data_we and m_data_byteen are 0. m_data_addr and m_data_wdata hold their last values.

## Timing
- Reset: state IDLE and all outputs 0, including DMOUT_M, exc_code_M and the counter. Asserting reset mid-access drops m_data_req immediately (asynchronously). A later ack is ignored.
- Legal access accepted in cycle t: REQ runs from t+1. If ack arrives in cycle t+1+k, DONE is cycle t+2+k. The minimum is 3 cycles, with stall_M = 1 in t..t+1+k.
- Illegal access in cycle t: EXC is cycle t+1. stall_M = 1 in t only.
- If ack and the timeout coincide on the TIMEOUT-th REQ cycle, ack wins and the FSM goes to DONE.
- An ack while m_data_req = 0 has no effect.
- Back-to-back memops: the next instruction is evaluated in the IDLE cycle after DONE or EXC. There is no idle gap beyond that cycle.
- DMOUT_M keeps its value until the next load completes. Stores and exceptions do not change it.

## Test plan
- Ack arrives on the first REQ cycle in each case:
  - sw addr 0x10, WD 0x12345678: req at t+1, byteen 1111, wdata 0x12345678; done_M at t+2; stall high in t and t+1.
  - sb addr 0x13, WD 0x000000AB: byteen 1000, wdata 0xAB000000.
  - lb addr 0x11, rdata 0x0000_80FF: DMOUT 0xFFFFFF80.
  - lbu addr 0x11, rdata 0x0000_80FF: DMOUT 0x00000080.
  - lh addr 0x12, rdata 0x8001_0000: DMOUT 0xFFFF8001.
  - lhu addr 0x12, rdata 0x8001_0000: DMOUT 0x00008001.
- Misaligned and out-of-range accesses:
  - lw addr 0x02 → exc_M pulse at t+1, code 4, req never asserted.
  - sh addr 0x3001 → code 5.
  - sb addr 0x3000 → code 5 (range).
- Ack delayed 5 cycles on lw addr 0x20 → req and bus outputs stable for 6 cycles, done_M exactly once, DMOUT = rdata.
- No ack, TIMEOUT = 16 → 16 REQ cycles, then exc_M with code 7.
- No ack, ack on the 16th REQ cycle → done_M, no exc_M.
- Reset low during REQ → req drops within the same cycle, all outputs 0. After release, an ack is ignored and the state is IDLE.
- Back-to-back sw then lw, with a non-memop and valid_M = 0 interleaved → two done_M pulses separated by one IDLE cycle; the non-memop produces no stall and no req.

Source files
------------

// File: rtl/m_mem_access.sv
// M-stage data access unit: decodes the load/store in M and masters a handshaked data bus.
// It stalls the pipeline until ack, returns extended load data and flags address and timeout errors.
module m_mem_access #(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_M,
  input  logic [31:0] INSTR_M,
  input  logic [31:0] ALUOUT_M,
  input  logic [31:0] WD_M,
  output logic        stall_M,
  output logic        done_M,
  output logic [31:0] DMOUT_M,
  output logic        exc_M,
  output logic [4:0]  exc_code_M,
  output logic        m_data_req,
  output logic        m_data_we,
  output logic [31:0] m_data_addr,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_wdata,
  input  logic        m_data_ack,
  input  logic [31:0] m_data_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_EXC  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_q;
  logic [1:0]       lane_q;
  logic             sign_q;
  logic             we_q;
  logic [3:0]       byteen_q;

  logic [5:0]  opcode;
  logic        is_load, is_store, is_signed, memop;
  logic [1:0]  size, lane;
  logic [3:0]  byteen;
  logic        misaligned, out_of_range;
  logic [32:0] base_diff, limit_diff;
  logic [31:0] load_ext;
  logic        unused_bits;

  assign opcode = INSTR_M[31:26];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_WORD;
    case (opcode)
      6'b100011: begin is_load = 1'b1;  size = SZ_WORD; end
      6'b100001: begin is_load = 1'b1;  size = SZ_HALF; is_signed = 1'b1; end
      6'b100101: begin is_load = 1'b1;  size = SZ_HALF; end
      6'b100000: begin is_load = 1'b1;  size = SZ_BYTE; is_signed = 1'b1; end
      6'b100100: begin is_load = 1'b1;  size = SZ_BYTE; end
      6'b101011: begin is_store = 1'b1; size = SZ_WORD; end
      6'b101001: begin is_store = 1'b1; size = SZ_HALF; end
      6'b101000: begin is_store = 1'b1; size = SZ_BYTE; end
      default: ;
    endcase
  end

  assign memop = valid_M & (is_load | is_store);

  // 33-bit differences: the borrow bit is the range test, valid for any base including zero.
  assign base_diff    = {1'b0, ALUOUT_M} - {1'b0, DM_BASE};
  assign limit_diff   = {1'b0, DM_LIMIT} - {1'b0, ALUOUT_M};
  assign out_of_range = base_diff[32] | limit_diff[32];

  always_comb begin
    misaligned = 1'b0;
    lane       = ALUOUT_M[1:0];
    byteen     = 4'b1111;
    case (size)
      SZ_WORD: begin
        misaligned = |ALUOUT_M[1:0];
        lane       = 2'd0;
      end
      SZ_HALF: begin
        misaligned = ALUOUT_M[0];
        lane       = {ALUOUT_M[1], 1'b0};
        byteen     = ALUOUT_M[1] ? 4'b1100 : 4'b0011;
      end
      default: byteen = 4'b0001 << ALUOUT_M[1:0];
    endcase
  end

  always_comb begin
    load_ext = m_data_rdata;
    case (size_q)
      SZ_BYTE: load_ext = {{24{sign_q & m_data_rdata[{lane_q, 3'b111}]}},
                           m_data_rdata[{lane_q, 3'b000} +: 8]};
      SZ_HALF: load_ext = {{16{sign_q & m_data_rdata[{lane_q[1], 4'b1111}]}},
                           m_data_rdata[{lane_q[1], 4'b0000} +: 16]};
      default: load_ext = m_data_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: every register, captured bus fields included, is cleared so reset shows all-zero outputs.
      state        <= S_IDLE;
      cnt          <= '0;
      size_q       <= SZ_BYTE;
      lane_q       <= 2'd0;
      sign_q       <= 1'b0;
      we_q         <= 1'b0;
      byteen_q     <= 4'b0;
      m_data_addr  <= 32'b0;
      m_data_wdata <= 32'b0;
      DMOUT_M      <= 32'b0;
      exc_code_M   <= 5'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (memop) begin
            if (misaligned | out_of_range) begin
              exc_code_M <= is_load ? EXC_ADEL : EXC_ADES;
              state      <= S_EXC;
            end else begin
              m_data_addr  <= ALUOUT_M;
              m_data_wdata <= WD_M << {lane, 3'b000};
              we_q         <= is_store;
              byteen_q     <= is_store ? byteen : 4'b0;
              size_q       <= size;
              sign_q       <= is_signed;
              lane_q       <= lane;
              cnt          <= '0;
              state        <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (m_data_ack) begin
            if (!we_q) DMOUT_M <= load_ext;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              exc_code_M <= EXC_DBE;
              state      <= S_EXC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_data_req    = (state == S_REQ);
  assign m_data_we     = m_data_req & we_q;
  assign m_data_byteen = m_data_req ? byteen_q : 4'b0;
  assign stall_M       = ((state == S_IDLE) & memop) | m_data_req;
  assign done_M        = (state == S_DONE);
  assign exc_M         = (state == S_EXC);

  assign unused_bits = ^{INSTR_M[25:0], base_diff[31:0], limit_diff[31:0]};

endmodule

// File: tb/tb_m_mem_access.sv
// Bench for m_mem_access: directed vector table, reset/back-to-back sequences and
// randomized accesses checked against an arithmetic model of the load/store rules.
module tb_m_mem_access;
  localparam int     TIMEOUT = 16;
  localparam longint BASE_L  = 64'h0000_0000;
  localparam longint LIMIT_L = 64'h0000_2FFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M;
  logic [31:0] INSTR_M, ALUOUT_M, WD_M;
  logic        stall_M, done_M, exc_M;
  logic [31:0] DMOUT_M;
  logic [4:0]  exc_code_M;
  logic        m_data_req, m_data_we, m_data_ack;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] prev_dmout;

  m_mem_access #(.DM_BASE(32'h0000_0000), .DM_LIMIT(32'h0000_2FFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .INSTR_M(INSTR_M), .ALUOUT_M(ALUOUT_M),
    .WD_M(WD_M), .stall_M(stall_M), .done_M(done_M), .DMOUT_M(DMOUT_M), .exc_M(exc_M),
    .exc_code_M(exc_code_M), .m_data_req(m_data_req), .m_data_we(m_data_we),
    .m_data_addr(m_data_addr), .m_data_byteen(m_data_byteen), .m_data_wdata(m_data_wdata),
    .m_data_ack(m_data_ack), .m_data_rdata(m_data_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_at;   // REQ cycle index carrying ack, -1 = never
    bit          exc;
    logic [4:0]  code;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] dmout;
  } vec_t;

  vec_t vecs[12];
  logic [5:0] memops[8] = '{6'b100011, 6'b100001, 6'b100101, 6'b100000,
                            6'b100100, 6'b101011, 6'b101001, 6'b101000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: size from the opcode, legality from modular arithmetic and the address window.
  task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input int ack_at,
                       output bit exc, output logic [4:0] code, output logic [3:0] be,
                       output logic [31:0] wdata, output logic [31:0] dmout);
    int size, off;
    bit st, sgn;
    longint unsigned mask, val;
    st = (op[5:3] == 3'b101);
    case (op)
      6'b100011, 6'b101011:             size = 4;
      6'b100001, 6'b100101, 6'b101001: size = 2;
      default:                          size = 1;
    endcase
    sgn  = (op == 6'b100000) || (op == 6'b100001);
    off  = int'(addr % 4);
    exc  = 1'b0;
    code = 5'd0;
    if ((addr % size) != 0 || longint'(addr) < BASE_L || longint'(addr) > LIMIT_L) begin
      exc  = 1'b1;
      code = st ? 5'd5 : 5'd4;
    end else if (ack_at < 0) begin
      exc  = 1'b1;
      code = 5'd7;
    end
    be    = st ? 4'(((1 << size) - 1) << off) : 4'd0;
    wdata = wd << (8 * off);
    mask  = (64'd1 << (8 * size)) - 1;
    val   = (longint'(rdata) >> (8 * off)) & mask;
    if (sgn && val[8 * size - 1]) val = val | ~mask;
    dmout = val[31:0];
  endtask

  // Called at an IDLE cycle; returns in the IDLE cycle after DONE/EXC.
  task automatic run_access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ack_at,
                            input bit exp_exc, input logic [4:0] exp_code, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_dmout,
                            output int end_cyc);
    int t0, n_req, exp_req;
    bit fin, st;
    st       = (op[5:3] == 3'b101);
    exp_req  = !exp_exc ? ack_at + 1 : (exp_code == 5'd7 ? TIMEOUT : 0);
    valid_M  = 1'b1;
    INSTR_M  = {op, 26'($urandom)};
    ALUOUT_M = addr;
    WD_M     = wd;
    m_data_ack = 1'b0;
    t0 = cyc;
    #1;
    check({tag, " accept stall"}, 32'(stall_M), 32'd1);
    check({tag, " accept req"}, 32'(m_data_req), 32'd0);
    n_req = 0;
    fin   = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      step();
      if (done_M || exc_M) begin
        fin = 1'b1;
      end else begin
        check({tag, " req"}, 32'(m_data_req), 32'd1);
        check({tag, " stall in req"}, 32'(stall_M), 32'd1);
        check({tag, " we"}, 32'(m_data_we), 32'(st));
        check({tag, " byteen"}, 32'(m_data_byteen), 32'(exp_be));
        check({tag, " addr"}, m_data_addr, addr);
        if (st) check({tag, " wdata"}, m_data_wdata, exp_wdata);
        m_data_ack   = (n_req == ack_at);
        m_data_rdata = m_data_ack ? rdata : $urandom;
        n_req++;
      end
    end
    m_data_ack = 1'b0;
    valid_M    = 1'b0;
    end_cyc    = cyc;
    check({tag, " finished within bound"}, 32'(fin), 32'd1);
    check({tag, " end cycle"}, 32'(cyc - t0), 32'(1 + exp_req));
    check({tag, " req cycles"}, 32'(n_req), 32'(exp_req));
    check({tag, " done_M"}, 32'(done_M), 32'(!exp_exc));
    check({tag, " exc_M"}, 32'(exc_M), 32'(exp_exc));
    check({tag, " stall at end"}, 32'(stall_M), 32'd0);
    check({tag, " req at end"}, 32'(m_data_req), 32'd0);
    if (exp_exc) check({tag, " exc_code"}, 32'(exc_code_M), 32'(exp_code));
    if (!exp_exc && !st) prev_dmout = exp_dmout;
    check({tag, " DMOUT"}, DMOUT_M, prev_dmout);
    step();
    check({tag, " single pulse"}, 32'({done_M, exc_M}), 32'd0);
  endtask

  task automatic run_model(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input int ack_at, output int end_cyc);
    bit exc;
    logic [4:0] code;
    logic [3:0] be;
    logic [31:0] wd, rdata, wdata, dmout;
    wd    = $urandom;
    rdata = $urandom;
    model(op, addr, wd, rdata, ack_at, exc, code, be, wdata, dmout);
    run_access(tag, op, addr, wd, rdata, ack_at, exc, code, be, wdata, dmout, end_cyc);
  endtask

  task automatic run_nonmemop(input string tag, input bit vld, input logic [5:0] op);
    valid_M  = vld;
    INSTR_M  = {op, 26'($urandom)};
    ALUOUT_M = 32'h0000_0040;
    #1;
    check({tag, " stall"}, 32'(stall_M), 32'd0);
    check({tag, " req"}, 32'(m_data_req), 32'd0);
    step();
    check({tag, " no req next"}, 32'(m_data_req), 32'd0);
    check({tag, " no pulse"}, 32'({done_M, exc_M}), 32'd0);
    valid_M = 1'b0;
  endtask

  initial begin
    int d1, d2, ack_at;
    logic [31:0] addr;
    logic [5:0] op;

    vecs[0]  = '{6'b101011, 32'h10,   32'h1234_5678, 32'h0,         0,  0, 5'd0, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[1]  = '{6'b101000, 32'h13,   32'h0000_00AB, 32'h0,         0,  0, 5'd0, 4'b1000, 32'hAB00_0000, 32'h0};
    vecs[2]  = '{6'b100000, 32'h11,   32'h0,         32'h0000_80FF, 0,  0, 5'd0, 4'b0000, 32'h0, 32'hFFFF_FF80};
    vecs[3]  = '{6'b100100, 32'h11,   32'h0,         32'h0000_80FF, 0,  0, 5'd0, 4'b0000, 32'h0, 32'h0000_0080};
    vecs[4]  = '{6'b100001, 32'h12,   32'h0,         32'h8001_0000, 0,  0, 5'd0, 4'b0000, 32'h0, 32'hFFFF_8001};
    vecs[5]  = '{6'b100101, 32'h12,   32'h0,         32'h8001_0000, 0,  0, 5'd0, 4'b0000, 32'h0, 32'h0000_8001};
    vecs[6]  = '{6'b100011, 32'h02,   32'h0,         32'h0,         0,  1, 5'd4, 4'b0000, 32'h0, 32'h0};
    vecs[7]  = '{6'b101001, 32'h3001, 32'h0,         32'h0,         0,  1, 5'd5, 4'b0000, 32'h0, 32'h0};
    vecs[8]  = '{6'b101000, 32'h3000, 32'h0,         32'h0,         0,  1, 5'd5, 4'b0000, 32'h0, 32'h0};
    vecs[9]  = '{6'b100011, 32'h20,   32'h0,         32'hDEAD_BEEF, 5,  0, 5'd0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
    vecs[10] = '{6'b100011, 32'h24,   32'h0,         32'h0,         -1, 1, 5'd7, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{6'b100011, 32'h28,   32'h0,         32'hC0FF_EE00, 15, 0, 5'd0, 4'b0000, 32'h0, 32'hC0FF_EE00};

    reset = 1'b0;
    valid_M = 1'b0;
    INSTR_M = 32'h0;
    ALUOUT_M = 32'h0;
    WD_M = 32'h0;
    m_data_ack = 1'b0;
    m_data_rdata = 32'h0;
    prev_dmout = 32'h0;
    repeat (3) step();
    check("reset req", 32'(m_data_req), 32'd0);
    check("reset addr", m_data_addr, 32'h0);
    check("reset wdata", m_data_wdata, 32'h0);
    check("reset DMOUT", DMOUT_M, 32'h0);
    check("reset exc_code", 32'(exc_code_M), 32'd0);
    check("reset pulses", 32'({stall_M, done_M, exc_M, m_data_we, m_data_byteen}), 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 12; i++)
      run_access($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].rdata,
                 vecs[i].ack_at, vecs[i].exc, vecs[i].code, vecs[i].be, vecs[i].wdata,
                 vecs[i].dmout, d1);

    // Back-to-back: lw is accepted in the IDLE cycle right after the sw's DONE.
    run_model("b2b sw", 6'b101011, 32'h100, 0, d1);
    run_model("b2b lw", 6'b100011, 32'h104, 0, d2);
    check("b2b done spacing", 32'(d2 - d1), 32'd3);
    run_nonmemop("r-type", 1'b1, 6'b000000);
    run_nonmemop("invalid lw", 1'b0, 6'b100011);
    run_model("after nonmemop lh", 6'b100001, 32'h2FFE, 1, d1);

    // Reset mid-REQ: req falls asynchronously; a later ack must be ignored.
    valid_M  = 1'b1;
    INSTR_M  = {6'b100011, 26'h0};
    ALUOUT_M = 32'h40;
    step();
    check("rst pre req", 32'(m_data_req), 32'd1);
    #2;
    reset   = 1'b0;
    valid_M = 1'b0;
    #1;
    check("rst req drop", 32'(m_data_req), 32'd0);
    check("rst addr", m_data_addr, 32'h0);
    check("rst DMOUT", DMOUT_M, 32'h0);
    check("rst others", 32'({stall_M, done_M, exc_M, m_data_we, m_data_byteen, exc_code_M}), 32'd0);
    step();
    reset        = 1'b1;
    m_data_ack   = 1'b1;
    m_data_rdata = 32'hFFFF_FFFF;
    prev_dmout   = 32'h0;
    step();
    check("post-rst ack ignored", 32'({m_data_req, done_M, exc_M}), 32'd0);
    check("post-rst DMOUT", DMOUT_M, 32'h0);
    m_data_ack = 1'b0;
    step();

    for (int i = 0; i < 40; i++) begin
      op = memops[$urandom_range(7, 0)];
      if ($urandom_range(5, 0) == 0) addr = $urandom_range(32'h3010, 32'h2FF0);
      else addr = $urandom_range(32'h2FFF, 32'h0);
      ack_at = (i % 10 == 9) ? -1 : int'($urandom_range(4, 0));
      run_model($sformatf("rnd%0d", i), op, addr, ack_at, d1);
      if (i % 4 == 3) run_nonmemop($sformatf("rnd nm%0d", i), 1'b1, 6'b001000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
